// File: rtl/data_memory_banked_if.sv
// CPU-side request/response bundle for the banked data memory.
// The master issues load/store requests; the slave answers with ready, rvalid, DataRd and err.
interface data_memory_banked_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              DMWR;
  logic [2:0]        DMCtrl;
  logic [ADDR_W-1:0] address;
  logic [31:0]       writeData;
  logic              ready;
  logic              rvalid;
  logic [31:0]       DataRd;
  logic              err;

  modport master (
    output req, DMWR, DMCtrl, address, writeData,
    input  ready, rvalid, DataRd, err
  );

  modport slave (
    input  req, DMWR, DMCtrl, address, writeData,
    output ready, rvalid, DataRd, err
  );
endinterface

// File: rtl/data_memory_banked.sv
// Word-organised little-endian data memory with registered loads, fault detection,
// a zero-fill sequencer after reset and a registered byte-snoop port for the display.
module data_memory_banked #(
  parameter int DEPTH_BYTES = 64,
  parameter int ADDR_W      = 32,
  parameter int DISP_AW     = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  data_memory_banked_if.slave  bus,
  input  logic [DISP_AW-1:0]   disp_addr,
  output logic [7:0]           disp_data
);

  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W+1)'(DEPTH_BYTES);
  localparam logic [DISP_AW:0] DISP_LIM  = (DISP_AW+1)'(DEPTH_BYTES);

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   mem_q [WORDS];

  logic          rvalid_q;
  logic          err_q;
  logic [31:0]   dataRd_q;
  logic [7:0]    dispData_q;

  logic          ready;
  logic          accept;
  logic          fault;
  logic          badCtrl;
  logic          misaligned;
  logic          outOfRange;
  logic [2:0]    size;
  logic [ADDR_W:0] endAddr;
  logic [CW-1:0] wordIdx;
  logic [3:0]    byteEn;
  logic [31:0]   laneData;
  logic          storeEn;
  logic          loadEn;
  logic [31:0]   rdWord;
  logic [7:0]    rdByte;
  logic [15:0]   rdHalf;
  logic [31:0]   loadData;
  logic [31:0]   dispWord;
  logic          dispInRange;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ready   = 1'b0;
    case (state_q)
      CLEAR: begin
        count_d = count_q + CW'(1);
        if (count_q == CW'(WORDS - 1)) begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      IDLE: begin
        ready = 1'b1;
      end
      default: begin
        state_d = CLEAR;
        count_d = '0;
      end
    endcase
  end

  // Size and legality decode; the range check runs one bit wider so address+3 cannot wrap.
  always_comb begin
    size       = 3'd1;
    badCtrl    = 1'b0;
    misaligned = 1'b0;
    case (bus.DMCtrl)
      3'b000, 3'b100: size = 3'd1;
      3'b001, 3'b101: begin
        size       = 3'd2;
        misaligned = bus.address[0];
      end
      3'b010: begin
        size       = 3'd4;
        misaligned = |bus.address[1:0];
      end
      default: badCtrl = 1'b1;
    endcase
  end

  assign endAddr    = {1'b0, bus.address} + (ADDR_W+1)'(size) - (ADDR_W+1)'(1);
  assign outOfRange = (endAddr >= DEPTH_EXT);
  assign fault      = badCtrl | misaligned | outOfRange;
  assign accept     = bus.req & ready;
  assign storeEn    = accept & bus.DMWR & ~fault & ~rst;
  assign loadEn     = accept & ~bus.DMWR;
  assign wordIdx    = bus.address[CW+1:2];

  always_comb begin
    byteEn   = 4'b1111;
    laneData = bus.writeData;
    case (bus.DMCtrl[1:0])
      2'b00: begin
        byteEn   = 4'b0001 << bus.address[1:0];
        laneData = {4{bus.writeData[7:0]}};
      end
      2'b01: begin
        byteEn   = 4'b0011 << bus.address[1:0];
        laneData = {2{bus.writeData[15:0]}};
      end
      default: begin
        byteEn   = 4'b1111;
        laneData = bus.writeData;
      end
    endcase
  end

  assign rdWord = mem_q[wordIdx];
  assign rdByte = rdWord[{bus.address[1:0], 3'b000} +: 8];
  assign rdHalf = rdWord[{bus.address[1], 4'b0000} +: 16];

  always_comb begin
    loadData = rdWord;
    case (bus.DMCtrl)
      3'b000:  loadData = {{24{rdByte[7]}}, rdByte};
      3'b100:  loadData = {24'h0, rdByte};
      3'b001:  loadData = {{16{rdHalf[15]}}, rdHalf};
      3'b101:  loadData = {16'h0, rdHalf};
      default: loadData = rdWord;
    endcase
  end

  // Storage has no reset; the CLEAR sequence is the only thing that zeroes it.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR && !rst) begin
      mem_q[count_q] <= '0;
    end else if (storeEn) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) begin
          mem_q[wordIdx][8*b +: 8] <= laneData[8*b +: 8];
        end
      end
    end
  end

  assign dispWord    = mem_q[disp_addr[CW+1:2]];
  assign dispInRange = ({1'b0, disp_addr} < DISP_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      dataRd_q   <= '0;
      dispData_q <= '0;
    end else begin
      rvalid_q <= loadEn;
      err_q    <= accept & fault;
      if (loadEn) begin
        dataRd_q <= fault ? 32'h0 : loadData;
      end
      dispData_q <= dispInRange ? dispWord[{disp_addr[1:0], 3'b000} +: 8] : 8'h00;
    end
  end

  assign bus.ready  = ready;
  assign bus.rvalid = rvalid_q;
  assign bus.err    = err_q;
  assign bus.DataRd = dataRd_q;
  assign disp_data  = dispData_q;

endmodule

// File: doc/data_memory_banked.md
Name: data_memory_banked

Overview:
- Parametrised successor to the processor's byte-addressed data memory.
- Word-organised array of DEPTH_BYTES bytes, stored little-endian.
- Supports SB/SH/SW and LB/LH/LW/LBU/LHU with registered reads and a request/valid handshake.
- Adds alignment/range/encoding fault detection and a hardware zero-fill sequencer after reset.
- Adds an independent registered byte-snoop port for the VGA display path, replacing the fixed per-byte outputs.

Parameters:
- DEPTH_BYTES, 64, memory size in bytes; must be a multiple of 4 and at least 4.
- ADDR_W, 32, width of the CPU address port.
- DISP_AW, 6, width of the display byte index; covers DEPTH_BYTES.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  request strobe; accepted when req && ready.
- DMWR  in  1  1 = store, 0 = load; sampled with req.
- DMCtrl  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- address  in  ADDR_W  byte address.
- writeData  in  32  store data; the low bytes are used for B/H.
- ready  out  1  high when a request can be accepted.
- rvalid  out  1  one-cycle pulse: load result is on DataRd.
- DataRd  out  32  load result, extended per DMCtrl.
- err  out  1  one-cycle pulse: the accepted request faulted.
- disp_addr  in  DISP_AW  display byte index.
- disp_data  out  8  byte at disp_addr, registered.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: ready=0, rvalid=0, err=0, DataRd=0, disp_data=0. FSM enters CLEAR with word counter=0.
- FSM states: CLEAR and IDLE.
- CLEAR:
  - Writes 32'h0 to word[counter] each cycle; counter increments.
  - When counter==DEPTH_BYTES/4-1 is written, go to IDLE next cycle.
  - Fill takes exactly DEPTH_BYTES/4 cycles after rst deasserts.
  - ready=0 throughout; req is ignored with no rvalid and no err.
  - rst asserted mid-CLEAR restarts the fill at counter=0.
- IDLE: ready=1. rst asserted in IDLE returns to CLEAR; the next cycle's ready=0.
- Fault checks on an accepted request; any one causes a fault:
  - DMCtrl is 011, 110 or 111.
  - H/HU with address[0]!=0.
  - W with address[1:0]!=0.
  - address+size-1 >= DEPTH_BYTES (out of range).
- Store, accepted in cycle N:
  - Byte lanes selected by address[1:0] and size are written at the edge ending cycle N.
  - Other lanes are unchanged.
  - No rvalid.
  - On fault: no lane written; err=1 in cycle N+1.
- Load, accepted in cycle N:
  - In cycle N+1, rvalid=1 and DataRd holds the result.
  - B/H sign-extend; BU/HU zero-extend; W is unchanged.
  - On fault: rvalid=1, DataRd=0, err=1 in N+1.
- DataRd holds its value until the next load completes.
- Back-to-back: a store accepted in N followed by a load of the same bytes accepted in N+1 returns the new data. One request per cycle; full throughput in IDLE.
- Display port:
  - disp_data <= byte[disp_addr] every cycle, 1-cycle latency, in both states.
  - A store and a snoop of the same byte in the same cycle returns the old byte (read-before-write).
  - disp_addr >= DEPTH_BYTES returns 8'h00.
- Arithmetic: range check is done at ADDR_W+1 bits so address+3 cannot wrap.
- Storage: memory is not reset combinationally; it is zeroed only by the CLEAR sequence.

Test Plan:
- Reset fill (DEPTH_BYTES=64): pulse rst 1 cycle, then hold req=1 every cycle.
  - Required: ready=0 for exactly 16 cycles, then 1; no rvalid or err during the fill.
  - Then LW @0x3C -> DataRd=0.
- Store/load widths:
  - SW 0x8765_43A1 @0x10, then LB @0x10 -> 0xFFFF_FFA1; LBU @0x10 -> 0x0000_00A1; LH @0x12 -> 0xFFFF_8765; LHU @0x12 -> 0x0000_8765; LW @0x10 -> 0x8765_43A1.
  - Each result has rvalid exactly 1 cycle after req.
- Partial write:
  - SW 0xFFFF_FFFF @0x20, SB 0x5A @0x21, SH 0x1234 @0x22, then LW @0x20 -> 0x1234_5AFF.
- Faults:
  - SW @0x22 -> err=1 next cycle; LW @0x20 still returns its prior value.
  - LH @0x13 -> rvalid=1, err=1, DataRd=0.
  - LW @0x3E -> err; DMCtrl=3'b011 -> err.
  - LW @0x3C -> no err.
- Reset mid-operation:
  - SW 0xDEAD_BEEF @0x8, assert rst during fill cycle 5, release.
  - Required: a full 16-cycle fill follows, and LW @0x8 -> 0.
- Display snoop:
  - SB 0x7E @0x05 in cycle N with disp_addr=5 -> disp_data=old byte in N+1, 0x7E in N+2.
  - disp_addr=63 (out of range when DEPTH_BYTES=48) -> 0x00.
